// File: rtl/ipf_conv_engine.sv
// Sliding 3-row window convolution engine: for every full window it emits one
// LANES-wide dot-product beat per stored 3x3 kernel, with valid/ready on both sides.
module ipf_conv_engine #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int KSETS  = 4,
  parameter int ACC_W  = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    ctrl,
  input  logic                          signed_mode,
  input  logic [9*DATA_W-1:0]           w_data,
  input  logic [$clog2(KSETS)-1:0]      w_sel,
  input  logic                          w_valid,
  input  logic [(LANES+2)*DATA_W-1:0]   row_data,
  input  logic                          row_valid,
  output logic                          row_ready,
  output logic [LANES*ACC_W-1:0]        res_data,
  output logic [$clog2(KSETS)-1:0]      res_kset,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          finish
);

  localparam int KW     = $clog2(KSETS);
  localparam int RW     = (LANES + 2) * DATA_W;
  localparam int OW     = LANES * ACC_W;
  localparam int OP_W   = DATA_W + 1;
  localparam int PROD_W = 2 * OP_W;
  localparam int SUM_W  = 2 * DATA_W + 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_FINISH  = 2'd2;

  localparam logic [1:0] CMD_END   = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_HOLD  = 2'd2;

  if (ACC_W < 2 * DATA_W + 4) begin : g_bad_acc_w
    $error("ipf_conv_engine: ACC_W must be at least 2*DATA_W+4");
  end
  if (KSETS < 2 || (KSETS & (KSETS - 1)) != 0) begin : g_bad_ksets
    $error("ipf_conv_engine: KSETS must be a power of 2 and at least 2");
  end

  logic [1:0]          state_reg;
  logic                mode_reg;
  logic [RW-1:0]       win_reg [3];
  logic [1:0]          fill_reg;
  logic [KW-1:0]       kcnt_reg;
  logic                done_reg;
  logic [9*DATA_W-1:0] kern_reg [KSETS];
  logic [OW-1:0]       res_data_reg;
  logic [KW-1:0]       res_kset_reg;
  logic                res_valid_reg;

  logic                is_compute;
  logic                cmd_end;
  logic                cmd_start;
  logic                cmd_hold;
  logic                row_acc;
  logic                issue;
  logic                last_k;
  logic [9*DATA_W-1:0] kern_cur;
  logic [OW-1:0]       lane_vec;

  assign is_compute = (state_reg == ST_COMPUTE);
  assign cmd_end    = (ctrl == CMD_END);
  assign cmd_start  = (ctrl == CMD_START);
  assign cmd_hold   = (ctrl == CMD_HOLD);

  // done gates row_ready, so a row accept and the final issue never share a cycle
  assign row_ready = is_compute && ((fill_reg != 2'd3) || done_reg);
  assign row_acc   = row_valid && row_ready;
  assign issue     = is_compute && (fill_reg == 2'd3) && !done_reg && !cmd_end && !cmd_hold &&
                     (!res_valid_reg || res_ready);
  assign last_k    = (kcnt_reg == KW'(KSETS - 1));
  assign kern_cur  = kern_reg[kcnt_reg];

  assign res_data  = res_data_reg;
  assign res_kset  = res_kset_reg;
  assign res_valid = res_valid_reg;
  assign busy      = is_compute;
  assign finish    = (state_reg == ST_FINISH);

  // Operands are widened by one bit (sign or zero per mode) so one signed
  // multiplier array serves both arithmetic modes.
  genvar gi, gk;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [SUM_W-1:0] terms [9];
    logic signed [SUM_W-1:0] lane_sum;

    for (gk = 0; gk < 9; gk++) begin : g_tap
      localparam int R = gk / 3;
      localparam int C = gk % 3;
      logic [DATA_W-1:0]        w_raw;
      logic [DATA_W-1:0]        p_raw;
      logic signed [OP_W-1:0]   w_op;
      logic signed [OP_W-1:0]   p_op;
      logic signed [PROD_W-1:0] prod;

      assign w_raw     = kern_cur[gk*DATA_W +: DATA_W];
      assign p_raw     = win_reg[R][(gi+C)*DATA_W +: DATA_W];
      assign w_op      = {mode_reg & w_raw[DATA_W-1], w_raw};
      assign p_op      = {mode_reg & p_raw[DATA_W-1], p_raw};
      assign prod      = PROD_W'(w_op) * PROD_W'(p_op);
      assign terms[gk] = SUM_W'(prod);
    end

    always_comb begin
      lane_sum = '0;
      for (int t = 0; t < 9; t++) begin
        lane_sum = lane_sum + terms[t];
      end
    end

    assign lane_vec[gi*ACC_W +: ACC_W] = ACC_W'(lane_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_start) begin
            state_reg <= ST_COMPUTE;
            mode_reg  <= signed_mode;
          end else if (cmd_end) begin
            state_reg <= ST_FINISH;
          end
        end
        ST_COMPUTE: begin
          if (cmd_end) begin
            state_reg <= ST_FINISH;
          end else if (cmd_hold) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_FINISH: state_reg <= ST_FINISH;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KSETS; i++) begin
        kern_reg[i] <= '0;
      end
    end else if (state_reg == ST_IDLE && w_valid) begin
      kern_reg[w_sel] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win_reg[i] <= '0;
      end
    end else if (row_acc) begin
      win_reg[0] <= win_reg[1];
      win_reg[1] <= win_reg[2];
      win_reg[2] <= row_data;
    end
  end

  // Window bookkeeping; a HOLD overrides any progress made in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg <= 2'd0;
      kcnt_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      if (row_acc) begin
        if (fill_reg == 2'd3) begin
          done_reg <= 1'b0;
          kcnt_reg <= '0;
        end else begin
          fill_reg <= fill_reg + 2'd1;
        end
      end
      if (issue) begin
        if (last_k) begin
          kcnt_reg <= '0;
          done_reg <= 1'b1;
        end else begin
          kcnt_reg <= kcnt_reg + KW'(1);
        end
      end
      if (is_compute && cmd_hold && !cmd_end) begin
        fill_reg <= 2'd0;
        kcnt_reg <= '0;
        done_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_reg  <= '0;
      res_kset_reg  <= '0;
      res_valid_reg <= 1'b0;
    end else if (issue) begin
      res_data_reg  <= lane_vec;
      res_kset_reg  <= kcnt_reg;
      res_valid_reg <= 1'b1;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ipf_conv_engine.sv
// Scoreboard bench for ipf_conv_engine: a behavioural model pushes expected beats
// when a window completes; a monitor pops and compares each accepted beat.
module tb_ipf_conv_engine;

  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int KSETS  = 4;
  localparam int ACC_W  = 20;
  localparam int KW     = 2;
  localparam int RW     = (LANES + 2) * DATA_W;
  localparam int OW     = LANES * ACC_W;

  logic                clk;
  logic                rst;
  logic [1:0]          ctrl;
  logic                signed_mode;
  logic [9*DATA_W-1:0] w_data;
  logic [KW-1:0]       w_sel;
  logic                w_valid;
  logic [RW-1:0]       row_data;
  logic                row_valid;
  logic                row_ready;
  logic [OW-1:0]       res_data;
  logic [KW-1:0]       res_kset;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic                finish;

  ipf_conv_engine #(
    .DATA_W(DATA_W), .LANES(LANES), .KSETS(KSETS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .signed_mode(signed_mode),
    .w_data(w_data), .w_sel(w_sel), .w_valid(w_valid),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .res_data(res_data), .res_kset(res_kset), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] kset;
    logic [OW-1:0] data;
  } beat_t;

  beat_t               exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  logic [9*DATA_W-1:0] mkern [KSETS];
  logic [RW-1:0]       mwin [3];
  int                  mfill = 0;
  bit                  mmode = 1'b0;
  logic [OW-1:0]       obs_data [KSETS];

  function automatic int pix_val(input logic [DATA_W-1:0] x, input bit sm);
    if (sm && x[DATA_W-1]) return int'(x) - (1 << DATA_W);
    return int'(x);
  endfunction

  function automatic logic [OW-1:0] model_beat(input int k);
    logic [OW-1:0] v;
    logic [31:0]   s32;
    int            s;
    v = '0;
    for (int j = 0; j < LANES; j++) begin
      s = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s += pix_val(mkern[k][(r*3+c)*DATA_W +: DATA_W], mmode) *
               pix_val(mwin[r][(j+c)*DATA_W +: DATA_W], mmode);
      s32 = s;
      v[j*ACC_W +: ACC_W] = s32[ACC_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] rep(input int val);
    logic [OW-1:0] v;
    logic [31:0]   t;
    t = val;
    for (int j = 0; j < LANES; j++) v[j*ACC_W +: ACC_W] = t[ACC_W-1:0];
    return v;
  endfunction

  function automatic logic [RW-1:0] row_fill(input int val);
    logic [RW-1:0] v;
    logic [31:0]   t;
    t = val;
    for (int c = 0; c < LANES + 2; c++) v[c*DATA_W +: DATA_W] = t[DATA_W-1:0];
    return v;
  endfunction

  function automatic logic [9*DATA_W-1:0] kern_fill(input int val);
    logic [9*DATA_W-1:0] v;
    logic [31:0]         t;
    t = val;
    for (int e = 0; e < 9; e++) v[e*DATA_W +: DATA_W] = t[DATA_W-1:0];
    return v;
  endfunction

  task automatic load_kernel(input int sel, input logic [9*DATA_W-1:0] k);
    logic [31:0] s;
    s = sel;
    w_sel = s[KW-1:0];
    w_data = k;
    w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    mkern[sel] = k;
  endtask

  task automatic do_start(input bit sm);
    signed_mode = sm;
    ctrl = 2'd1;
    @(posedge clk); #1;
    ctrl = 2'd3;
    mmode = sm;
  endtask

  task automatic do_hold();
    ctrl = 2'd2;
    @(posedge clk); #1;
    ctrl = 2'd3;
    mfill = 0;
  endtask

  task automatic send_row(input logic [RW-1:0] r);
    int          n;
    bit          acc;
    logic [31:0] k32;
    n = 0;
    acc = 1'b0;
    row_data = r;
    row_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = row_ready;
      @(posedge clk); #1;
      n++;
    end
    row_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL row_accept_timeout: row_ready=%0b after %0d cycles, required 1", row_ready, n);
    end else begin
      mwin[0] = mwin[1];
      mwin[1] = mwin[2];
      mwin[2] = r;
      if (mfill < 3) mfill++;
      if (mfill == 3) begin
        for (int k = 0; k < KSETS; k++) begin
          k32 = k;
          exp_q.push_back('{kset: k32[KW-1:0], data: model_beat(k)});
        end
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || row_ready !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b rready=%b busy=%b finish=%b, required all 0",
               res_valid, row_ready, busy, finish);
    end
    checks++;
    if (res_data !== '0 || res_kset !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h kset=%0d, required 0", res_data, res_kset);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (row_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rready=%b busy=%b, required 0 0", row_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_kernel(0, kern_fill(1));
    for (int k = 1; k < KSETS; k++) load_kernel(k, kern_fill(0));
    do_start(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b, required 1", busy);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_row(row_fill(1));
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: res_valid=%b before first edge, required 0", res_valid);
    end
    for (int k = 0; k < KSETS; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_kset !== KW'(k) || res_data !== rep(k == 0 ? 9 : 0)) begin
        errors++;
        $display("FAIL basic_beat%0d: valid=%b kset=%0d data=%h, required 1 %0d %h",
                 k, res_valid, res_kset, res_data, k, rep(k == 0 ? 9 : 0));
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: valid=%b rready=%b, required 0 1", res_valid, row_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [9*DATA_W-1:0] id_k;
    logic [RW-1:0]       r0, r1, r2, r3;
    logic [OW-1:0]       e1, e2;
    logic [31:0]         t;
    bit                  ok;
    do_hold();
    id_k = '0;
    id_k[4*DATA_W +: DATA_W] = 8'd1;
    load_kernel(2, id_k);
    do_start(1'b0);
    for (int c = 0; c < LANES + 2; c++) begin
      r0[c*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
      t = c + 10;     r1[c*DATA_W +: DATA_W] = t[DATA_W-1:0];
      t = c * 3 + 1;  r2[c*DATA_W +: DATA_W] = t[DATA_W-1:0];
      r3[c*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
    end
    for (int j = 0; j < LANES; j++) begin
      t = j + 11;          e1[j*ACC_W +: ACC_W] = t[ACC_W-1:0];
      t = (j + 1) * 3 + 1; e2[j*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    send_row(r0);
    send_row(r1);
    send_row(r2);
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[2] !== e1) begin
      errors++;
      $display("FAIL identity_k2: drained=%0b data=%h, required 1 %h", ok, obs_data[2], e1);
    end
    send_row(r3);
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[2] !== e2) begin
      errors++;
      $display("FAIL identity_slide: drained=%0b data=%h, required 1 %h", ok, obs_data[2], e2);
    end
  endtask

  task automatic test_signed();
    bit ok;
    do_hold();
    for (int k = 0; k < KSETS; k++) load_kernel(k, kern_fill(2));
    do_start(1'b1);
    for (int i = 0; i < 3; i++) send_row(row_fill(8'hFF));
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[0] !== rep('hFFFEE)) begin
      errors++;
      $display("FAIL signed_lane: drained=%0b data=%h, required 1 %h", ok, obs_data[0], rep('hFFFEE));
    end
    do_hold();
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send_row(row_fill(8'hFF));
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[3] !== rep(4590)) begin
      errors++;
      $display("FAIL unsigned_lane: drained=%0b data=%h, required 1 %h", ok, obs_data[3], rep(4590));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    res_ready = 1'b0;
    send_row(row_fill(8'hFF));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_kset !== '0 || res_data !== rep(4590) || row_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b kset=%0d rready=%b data=%h, required 1 0 0 %h",
                 i, res_valid, res_kset, row_ready, res_data, rep(4590));
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_drain(ok);
    @(negedge clk);
    checks++;
    if (!ok || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: drained=%0b rready=%b, required 1 1", ok, row_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    bit ok;
    res_ready = 1'b1;
    send_row(row_fill(8'hFF));
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctrl = 2'd2;
    res_ready = 1'b0;
    @(posedge clk); #1;
    ctrl = 2'd3;
    mfill = 0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b1 || res_kset !== KW'(1)) begin
      errors++;
      $display("FAIL hold_pending: busy=%b valid=%b kset=%0d, required 0 1 1", busy, res_valid, res_kset);
    end
    res_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain: drained=%0b valid=%b, required 1 0", ok, res_valid);
    end
    load_kernel(1, kern_fill(3));
    do_start(1'b0);
    send_row(row_fill(1));
    send_row(row_fill(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_refill%0d: valid=%b with 2 rows, required 0", i, res_valid);
      end
    end
    @(posedge clk); #1;
    send_row(row_fill(1));
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[1] !== rep(27)) begin
      errors++;
      $display("FAIL hold_reload_k1: drained=%0b data=%h, required 1 %h", ok, obs_data[1], rep(27));
    end
  endtask

  task automatic test_overflow_end();
    bit ok;
    do_hold();
    for (int k = 0; k < KSETS; k++) load_kernel(k, kern_fill(8'hFF));
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send_row(row_fill(8'hFF));
    wait_drain(ok);
    checks++;
    if (!ok || obs_data[3] !== rep(585225)) begin
      errors++;
      $display("FAIL max_unsigned: drained=%0b data=%h, required 1 %h", ok, obs_data[3], rep(585225));
    end
    ctrl = 2'd0;
    @(posedge clk); #1;
    ctrl = 2'd3;
    checks++;
    if (finish !== 1'b1 || busy !== 1'b0 || row_ready !== 1'b0) begin
      errors++;
      $display("FAIL end_state: finish=%b busy=%b rready=%b, required 1 0 0", finish, busy, row_ready);
    end
    do_start(1'b0);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL finish_sticky: finish=%b busy=%b, required 1 0", finish, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_clears_finish: finish=%b busy=%b, required 0 0", finish, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl = 2'd3;
    signed_mode = 1'b0;
    w_data = '0;
    w_sel = '0;
    w_valid = 1'b0;
    row_data = '0;
    row_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < KSETS; k++) begin
      mkern[k] = '0;
      obs_data[k] = '0;
    end
    for (int r = 0; r < 3; r++) mwin[r] = '0;

    fork
      begin
        beat_t e;
        forever begin
          @(negedge clk);
          if (!rst && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL beat_unexpected: kset=%0d data=%h, required no beat", res_kset, res_data);
            end else begin
              e = exp_q.pop_front();
              if (res_kset !== e.kset || res_data !== e.data) begin
                errors++;
                $display("FAIL beat_compare: kset=%0d data=%h, required kset=%0d data=%h",
                         res_kset, res_data, e.kset, e.data);
              end
              obs_data[res_kset] = res_data;
            end
          end
        end
      end
    join_none

    test_reset();
    test_basic();
    test_identity();
    test_signed();
    test_back_to_back();
    test_hold();
    test_overflow_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
